spi_slave_fsm_param: RTL
========================

Name: spi_slave_fsm_param

Overview:
- Parametrised next-generation control FSM for the SPI slave.
- Sequences the address phase, the R/W bit and the data phase. Drives the address latch, shift-register parallel load, data-memory write and MISO tri-state enable.
- Adds configurable address/data widths, burst mode with address auto-increment, and abort detection when CS rises mid-transaction.
- Runs on the system clock; SPI timing arrives as a one-cycle sclk_edge strobe from the input conditioner.

Parameters:
- ADDR_BITS, 7: number of address bits shifted in before the R/W bit.
- DATA_BITS, 8: bits per data word.
- BURST, 1: 1 = consecutive words auto-increment the address until CS rises; 0 = single word per transaction.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sclk_edge  in  1  one-clk strobe marking the SCLK rising edge (conditioned).
- cs  in  1  chip select, active low (conditioned).
- rw  in  1  R/W bit from shift register; sampled only on sclk_edge in state RW.
- miso_buff  out  1  MISO output enable.
- addr_we  out  1  address latch write enable (level).
- sr_we  out  1  shift-register parallel-load pulse (1 clk).
- dm_we  out  1  data-memory write pulse (1 clk).
- addr_inc  out  1  address-latch increment pulse (1 clk).
- busy  out  1  high whenever state != IDLE.
- word_done  out  1  1-clk pulse per completed data word.
- abort  out  1  1-clk pulse when CS rises mid-word.

Behaviour:
- All outputs are registered. Reset forces state IDLE, counter 0 and all outputs 0. Reset takes priority over everything.
- cs high, checked every clk (not only on strobes):
  - next state IDLE; counter 0; all outputs 0 except abort.
  - A sclk_edge in the same clk is ignored.
- abort pulses for 1 clk when cs rises while in any of:
  - ADDR or RW;
  - RD or WR with counter != 0;
  - RD_RELOAD or WR_COMMIT.
  No abort when cs rises in IDLE, DONE, or in RD/WR with counter == 0.
- Counter width is $clog2(max(ADDR_BITS,DATA_BITS)). It compares against the parameter minus 1 and never wraps beyond it.
- States and transitions:
  - IDLE: on cs low, go to ADDR and set addr_we = 1. No strobe is needed.
  - ADDR: each sclk_edge increments counter. On the edge with counter == ADDR_BITS-1: addr_we = 0, counter = 0, go to RW.
  - RW: on sclk_edge, sample rw.
    - rw = 1: sr_we pulse, miso_buff = 1, go to RD.
    - rw = 0: go to WR.
  - RD: each sclk_edge increments counter. On the edge with counter == DATA_BITS-1: counter = 0, word_done pulse, then:
    - BURST = 1: addr_inc pulse, go to RD_RELOAD.
    - BURST = 0: miso_buff = 0, go to DONE.
  - RD_RELOAD: lasts 1 clk. sr_we pulse (loads the data at the incremented address), return to RD. miso_buff stays 1.
  - WR: each sclk_edge increments counter. On the edge with counter == DATA_BITS-1: counter = 0, word_done pulse, dm_we pulse, go to WR_COMMIT.
  - WR_COMMIT: lasts 1 clk.
    - BURST = 1: addr_inc pulse (after the write, so the write hits the current address), return to WR.
    - BURST = 0: go to DONE.
  - DONE: all enables 0; wait for cs high.
- Latencies: every output changes 1 clk after the sampling clk. sclk_edge must be ≥3 clks apart; RD_RELOAD and WR_COMMIT each consume exactly 1 clk.
- addr_we, sr_we, dm_we and addr_inc are never high together, except that sr_we and miso_buff rise together.

Test Plan:
- Write, BURST=0, ADDR_BITS=7, DATA_BITS=8: cs low, 7 address edges, rw=0 edge, 8 data edges -> addr_we high from clk after cs fall to clk after edge 7; exactly one dm_we pulse 1 clk after data edge 8; 8 further edges give no dm_we; busy=1 until cs high.
- Read, BURST=0: rw=1 edge -> sr_we 1-clk pulse and miso_buff=1 1 clk after that edge; miso_buff=0 1 clk after data edge 8; word_done one pulse.
- Burst write, BURST=1, 3 words (24 data edges), then cs high -> 3 dm_we pulses, each followed next clk by addr_inc; 3 word_done pulses; abort stays 0.
- Burst read, BURST=1, 2 words -> addr_inc 1 clk after edge 8; sr_we exactly 1 clk later; miso_buff continuously 1 through edge 16.
- Abort: cs high after 4 data edges of a write -> abort pulse, no dm_we, all outputs 0 and busy=0 next clk. Repeat with cs high during ADDR -> abort pulse, addr_we drops.
- Edge cases:
  - reset asserted mid-ADDR -> IDLE, all outputs 0 next clk.
  - sclk_edge coincident with cs rise -> edge ignored.
  - ADDR_BITS=4, DATA_BITS=16 with BURST=0 -> dm_we after data edge 16.

Source files
------------

// File: rtl/spi_slave_fsm_param.sv
// -----------------------------------------------------------------------------
// spi_slave_fsm_param
//   Control FSM for the SPI slave. Sequences the address phase, the R/W bit and
//   the data phase, and drives the address latch, shift-register parallel load,
//   data-memory write and MISO output enable. Address/data widths are
//   parameters. BURST enables multi-word transactions with address
//   auto-increment. A CS rise in the middle of a transaction raises abort.
//
//   SPI timing arrives as a one-clk sclk_edge strobe on the system clock.
//   Every output is registered, so each output follows its cause by one clk.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   sclk_edge  one-clk strobe marking an SCLK rising edge (conditioned)
//   cs         chip select, active low (conditioned)
//   rw         R/W bit from the shift register, sampled on sclk_edge in RW
//   miso_buff  MISO output enable
//   addr_we    address latch write enable (level, high during the address phase)
//   sr_we      shift-register parallel-load pulse
//   dm_we      data-memory write pulse
//   addr_inc   address-latch increment pulse
//   busy       high whenever the FSM is not idle
//   word_done  pulse per completed data word
//   abort      pulse when CS rises mid-transaction
// -----------------------------------------------------------------------------
module spi_slave_fsm_param #(
    parameter int ADDR_BITS = 7,
    parameter int DATA_BITS = 8,
    parameter bit BURST     = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic sclk_edge,
    input  logic cs,
    input  logic rw,
    output logic miso_buff,
    output logic addr_we,
    output logic sr_we,
    output logic dm_we,
    output logic addr_inc,
    output logic busy,
    output logic word_done,
    output logic abort
);

    // One counter serves both phases, so it is sized for the wider one.
    localparam int MAX_BITS = (ADDR_BITS > DATA_BITS) ? ADDR_BITS : DATA_BITS;
    localparam int CW       = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_BITS - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        RW,
        RD,
        RD_RELOAD,
        WR,
        WR_COMMIT,
        DONE
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;

    logic miso_buff_n, addr_we_n, sr_we_n, dm_we_n;
    logic addr_inc_n, busy_n, word_done_n, abort_n;

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        sr_we_n     = 1'b0;
        dm_we_n     = 1'b0;
        addr_inc_n  = 1'b0;
        word_done_n = 1'b0;
        abort_n     = 1'b0;

        if (cs) begin
            // CS high wins over any strobe in the same clk.
            state_n = IDLE;
            cnt_n   = '0;
            // A data state with counter 0 sits on a word boundary, so leaving
            // there is a clean end rather than an abort.
            case (state)
                ADDR, RW, RD_RELOAD, WR_COMMIT: abort_n = 1'b1;
                RD, WR:                         abort_n = (cnt != '0);
                default:                        abort_n = 1'b0;
            endcase
        end else begin
            case (state)
                IDLE: state_n = ADDR;

                ADDR: if (sclk_edge) begin
                    if (cnt == ADDR_LAST) begin
                        cnt_n   = '0;
                        state_n = RW;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end

                RW: if (sclk_edge) begin
                    if (rw) begin
                        sr_we_n = 1'b1;
                        state_n = RD;
                    end else begin
                        state_n = WR;
                    end
                end

                RD: if (sclk_edge) begin
                    if (cnt == DATA_LAST) begin
                        cnt_n       = '0;
                        word_done_n = 1'b1;
                        if (BURST) begin
                            addr_inc_n = 1'b1;
                            state_n    = RD_RELOAD;
                        end else begin
                            state_n = DONE;
                        end
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end

                // Address was bumped last clk; load the word it now points at.
                RD_RELOAD: begin
                    sr_we_n = 1'b1;
                    state_n = RD;
                end

                WR: if (sclk_edge) begin
                    if (cnt == DATA_LAST) begin
                        cnt_n       = '0;
                        word_done_n = 1'b1;
                        dm_we_n     = 1'b1;
                        state_n     = WR_COMMIT;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end

                // Increment one clk after dm_we so the write lands on the
                // current address.
                WR_COMMIT: begin
                    if (BURST) begin
                        addr_inc_n = 1'b1;
                        state_n    = WR;
                    end else begin
                        state_n = DONE;
                    end
                end

                DONE:    state_n = DONE;
                default: state_n = IDLE;
            endcase
        end

        // Level outputs follow the state being entered.
        addr_we_n   = (state_n == ADDR);
        miso_buff_n = (state_n == RD) || (state_n == RD_RELOAD);
        busy_n      = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            miso_buff <= 1'b0;
            addr_we   <= 1'b0;
            sr_we     <= 1'b0;
            dm_we     <= 1'b0;
            addr_inc  <= 1'b0;
            busy      <= 1'b0;
            word_done <= 1'b0;
            abort     <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            miso_buff <= miso_buff_n;
            addr_we   <= addr_we_n;
            sr_we     <= sr_we_n;
            dm_we     <= dm_we_n;
            addr_inc  <= addr_inc_n;
            busy      <= busy_n;
            word_done <= word_done_n;
            abort     <= abort_n;
        end
    end

endmodule
